// File: rtl/mic_volume_meter.sv
// Microphone volume meter: windowed peak detect above the silence baseline,
// quantised to a 0..MAX_LEVEL bar level with one-step-per-window decay.
module mic_volume_meter #(
    parameter int BASELINE       = 2048,
    parameter int WINDOW_SAMPLES = 2000,
    parameter int SHIFT          = 6,
    parameter int MAX_LEVEL      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [11:0] mic_in,
    output logic [4:0]  volume,
    output logic        volume_valid,
    output logic        clip
);

    localparam logic [15:0] LAST_IDX = 16'(WINDOW_SAMPLES - 1);
    localparam logic [4:0]  MAX_L    = 5'(MAX_LEVEL);

    logic [15:0]        cnt_p0;
    logic [10:0]        peak_p0;
    logic               clip_acc_p0;

    logic signed [12:0] diff;
    logic [10:0]        amp;
    logic [10:0]        peak_next;
    logic               clip_acc_next;

    // Peak is shifted down to bar resolution, then saturated at MAX_LEVEL.
    function automatic logic [4:0] sat_level(input logic [10:0] pk);
        logic [10:0] sh;
        sh = pk >> SHIFT;
        if (sh > 11'(MAX_L))
            return MAX_L;
        return sh[4:0];
    endfunction

    function automatic logic [4:0] decay(input logic [4:0] lvl, input logic [4:0] vol);
        if (lvl >= vol)
            return lvl;
        return (vol != 5'd0) ? vol - 5'd1 : 5'd0;
    endfunction

    always_comb begin
        diff          = $signed({1'b0, mic_in}) - $signed(13'(BASELINE));
        amp           = (diff > 13'sd0) ? diff[10:0] : 11'd0;
        peak_next     = (amp > peak_p0) ? amp : peak_p0;
        clip_acc_next = clip_acc_p0 | (mic_in == 12'd0) | (mic_in == 12'hFFF);
    end

    // Accumulate stage -> window-close output register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p0       <= '0;
            peak_p0      <= '0;
            clip_acc_p0  <= 1'b0;
            volume       <= '0;
            volume_valid <= 1'b0;
            clip         <= 1'b0;
        end else begin
            volume_valid <= 1'b0;
            if (sample_valid) begin
                if (cnt_p0 == LAST_IDX) begin
                    volume       <= decay(sat_level(peak_next), volume);
                    clip         <= clip_acc_next;
                    volume_valid <= 1'b1;
                    cnt_p0       <= '0;
                    peak_p0      <= '0;
                    clip_acc_p0  <= 1'b0;
                end else begin
                    cnt_p0      <= cnt_p0 + 16'd1;
                    peak_p0     <= peak_next;
                    clip_acc_p0 <= clip_acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_mic_volume_meter.sv
// Directed bench for mic_volume_meter with a window-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_mic_volume_meter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [11:0] mic_in = 12'd2048;
    logic [4:0]  volume;
    logic        volume_valid;
    logic        clip;

    int total = 0;
    int bad   = 0;

    int exp_vol  = 0;
    int exp_clip = 0;
    int exp_vv   = 0;
    bit armed    = 0;
    int win[$];

    mic_volume_meter #(.WINDOW_SAMPLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .mic_in       (mic_in),
        .volume       (volume),
        .volume_valid (volume_valid),
        .clip         (clip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    // Reference: whole-window view -- max amplitude over the stored samples,
    // any clipping code, then the decay rule on the displayed level.
    task automatic close_window();
        int mx;
        int lvl;
        bit cl;
        mx = 0;
        cl = 0;
        foreach (win[i]) begin
            if (win[i] - 2048 > mx) mx = win[i] - 2048;
            if (win[i] == 0 || win[i] == 4095) cl = 1;
        end
        lvl = mx / 64;
        if (lvl > 16) lvl = 16;
        if (lvl >= exp_vol) exp_vol = lvl;
        else if (exp_vol > 0) exp_vol = exp_vol - 1;
        exp_clip = cl;
        exp_vv   = 1;
        win.delete();
    endtask

    task automatic tick(input bit v, input int d, input bit r);
        sample_valid = v;
        mic_in       = 12'(d);
        reset        = r;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        reset        = 1'b0;
        exp_vv       = 0;
        if (r) begin
            win.delete();
            exp_vol  = 0;
            exp_clip = 0;
            armed    = 1;
        end else if (v) begin
            win.push_back(d);
            if (win.size() == 4) close_window();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 2048, 0);
    endtask

    task automatic window4(input int a, input int b, input int c, input int d, input int gap);
        tick(1, a, 0); idle(gap);
        tick(1, b, 0); idle(gap);
        tick(1, c, 0); idle(gap);
        tick(1, d, 0);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("volume", 32'(volume), 32'(exp_vol));
            chk("volume_valid", 32'(volume_valid), 32'(exp_vv));
            chk("clip", 32'(clip), 32'(exp_clip));
        end
    end

    initial begin
        // 1: reset then idle
        for (int i = 0; i < 3; i++) tick(0, 2048, 1);
        idle(100);
        chk("lit_idle_volume", 32'(volume), 32'd0);
        chk("lit_idle_clip", 32'(clip), 32'd0);

        // 2: single window, peak 1024 -> level 16
        window4(2048, 2200, 3072, 2100, 0);
        chk("lit_w1_valid", 32'(volume_valid), 32'd1);
        chk("lit_w1_volume", 32'(volume), 32'd16);
        idle(1);
        chk("lit_w1_valid_drop", 32'(volume_valid), 32'd0);

        // 3: decay with silent windows, gaps between strobes
        window4(2048, 2048, 2048, 2048, 2);
        chk("lit_decay15", 32'(volume), 32'd15);
        window4(2048, 2048, 2048, 2048, 0);
        chk("lit_decay14", 32'(volume), 32'd14);
        window4(2048, 2048, 2048, 2048, 5);
        chk("lit_decay13", 32'(volume), 32'd13);

        // 4: low level still decays, high level overrides
        window4(2048, 2368, 2048, 2048, 1);
        chk("lit_low_level", 32'(volume), 32'd12);
        window4(2048, 2048, 3000, 1000, 0);
        chk("lit_rise14", 32'(volume), 32'd14);

        // decay all the way, then one more silent window stays at 0
        for (int w = 0; w < 14; w++) window4(2048, 2048, 2048, 2048, 0);
        chk("lit_floor", 32'(volume), 32'd0);
        window4(2048, 2048, 2048, 2048, 3);
        chk("lit_no_underflow", 32'(volume), 32'd0);

        // 5: clipping high, clean window, clipping low
        window4(2048, 4095, 2048, 2048, 0);
        chk("lit_clip_hi", 32'(clip), 32'd1);
        chk("lit_clip_vol", 32'(volume), 32'd16);
        idle(4);
        chk("lit_clip_hold", 32'(clip), 32'd1);
        window4(2048, 2048, 2048, 2048, 0);
        chk("lit_clip_clear", 32'(clip), 32'd0);
        chk("lit_clip_vol2", 32'(volume), 32'd15);
        window4(0, 2048, 2048, 2048, 1);
        chk("lit_clip_lo", 32'(clip), 32'd1);
        chk("lit_clip_lo_vol", 32'(volume), 32'd14);

        // 6: reset mid-window discards partial window; strobe during reset ignored
        tick(1, 4000, 0);
        tick(1, 4000, 0);
        tick(1, 4000, 0);
        tick(1, 4000, 1);
        chk("lit_rst_volume", 32'(volume), 32'd0);
        tick(1, 2048, 0);
        tick(1, 2048, 0);
        tick(1, 2048, 0);
        chk("lit_rst_no_early_valid", 32'(volume_valid), 32'd0);
        tick(1, 2048, 0);
        chk("lit_rst_valid", 32'(volume_valid), 32'd1);
        chk("lit_rst_vol0", 32'(volume), 32'd0);
        chk("lit_rst_clip0", 32'(clip), 32'd0);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
